// File: rtl/pipeline_control_unit.sv
// pipeline_control_unit
//   Hazard and stall controller for a 5-stage pipeline (IF, OF, EX, MA, RW).
//   It resolves taken branches (flush IF/OF, bubble OF/EX), RAW interlocks
//   (freeze PC and IF/OF, bubble OF/EX) and multi-cycle mul/div/mod ops
//   (freeze everything upstream of MA, handshake with the MDU).
//
//   Optional build macro: PIPE_PERF_COUNTERS_EN enables the saturating
//   stall/flush performance counters; when undefined both read as 0.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   isDataInterLock           RAW hazard between OF and EX instructions
//   isBranchTaken             EX-stage branch resolved taken
//   input_EX_IR[31:0]         EX-stage instruction, opcode in [31:27]
//   mdu_done                  MDU result ready (one-cycle pulse)
//   pc_en .. ma_rw_en         load enables for PC and pipeline latches
//   if_of_flush, of_ex_bubble, ex_ma_bubble   load NOP into that latch
//   mdu_start                 one-cycle MDU start pulse
//   stall_cycles, flush_count performance counters (CNT_W bits)
module pipeline_control_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             isDataInterLock,
  input  logic             isBranchTaken,
  input  logic [31:0]      input_EX_IR,
  input  logic             mdu_done,
  output logic             pc_en,
  output logic             if_of_en,
  output logic             of_ex_en,
  output logic             ex_ma_en,
  output logic             ma_rw_en,
  output logic             if_of_flush,
  output logic             of_ex_bubble,
  output logic             ex_ma_bubble,
  output logic             mdu_start,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MDU_START = 2'd1,
    MDU_WAIT  = 2'd2,
    RELEASE   = 2'd3
  } state_t;

  localparam logic [4:0] OP_MUL = 5'b00010;
  localparam logic [4:0] OP_DIV = 5'b00011;
  localparam logic [4:0] OP_MOD = 5'b00100;

  state_t     state, state_next;
  logic [4:0] ex_opcode;
  logic       mdu_op;
  logic       unused_ir_bits;

  assign ex_opcode      = input_EX_IR[31:27];
  assign mdu_op         = (ex_opcode == OP_MUL) || (ex_opcode == OP_DIV) ||
                          (ex_opcode == OP_MOD);
  assign unused_ir_bits = ^input_EX_IR[26:0];

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  always_comb begin
    state_next   = state;
    pc_en        = 1'b0;
    if_of_en     = 1'b0;
    of_ex_en     = 1'b0;
    ex_ma_en     = 1'b0;
    ma_rw_en     = 1'b0;
    if_of_flush  = 1'b0;
    of_ex_bubble = 1'b0;
    ex_ma_bubble = 1'b0;
    mdu_start    = 1'b0;

    if (rst) begin
      state_next = RUN;
    end else begin
      unique case (state)
        RUN: begin
          if (isBranchTaken) begin
            {pc_en, if_of_en, of_ex_en, ex_ma_en, ma_rw_en} = '1;
            if_of_flush  = 1'b1;
            of_ex_bubble = 1'b1;
          end else if (mdu_op) begin
            // Hold the op in EX; MA receives a bubble while RW drains.
            ma_rw_en     = 1'b1;
            ex_ma_bubble = 1'b1;
            state_next   = MDU_START;
          end else if (isDataInterLock) begin
            of_ex_en     = 1'b1;
            ex_ma_en     = 1'b1;
            ma_rw_en     = 1'b1;
            of_ex_bubble = 1'b1;
          end else begin
            {pc_en, if_of_en, of_ex_en, ex_ma_en, ma_rw_en} = '1;
          end
        end
        MDU_START: begin
          ma_rw_en     = 1'b1;
          ex_ma_bubble = 1'b1;
          mdu_start    = 1'b1;
          state_next   = MDU_WAIT;
        end
        MDU_WAIT: begin
          ma_rw_en     = 1'b1;
          ex_ma_bubble = 1'b1;
          if (mdu_done) state_next = RELEASE;
        end
        RELEASE: begin
          // The finished op leaves EX now; mdu_op is not looked at here so
          // the same instruction cannot restart the unit.
          {pc_en, if_of_en, of_ex_en, ex_ma_en, ma_rw_en} = '1;
          state_next = RUN;
        end
        default: state_next = RUN;
      endcase
    end
  end

`ifdef PIPE_PERF_COUNTERS_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_en && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
      if (if_of_flush && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Testbench for pipeline_control_unit: table of per-cycle vectors for the
// main scenario (interlock, branch, mul/div/mod handshakes, reset in WAIT)
// plus a hand-written saturation sequence on a CNT_W=4 instance.
module tb_pipeline_control_unit;

`ifdef PIPE_PERF_COUNTERS_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_MUL = 5'b00010;
  localparam logic [4:0] OP_DIV = 5'b00011;
  localparam logic [4:0] OP_MOD = 5'b00100;

  // {pc_en, if_of_en, of_ex_en, ex_ma_en, ma_rw_en,
  //  if_of_flush, of_ex_bubble, ex_ma_bubble, mdu_start}
  localparam logic [8:0] O_RST  = 9'b00000_000_0;
  localparam logic [8:0] O_NORM = 9'b11111_000_0;
  localparam logic [8:0] O_MDU  = 9'b00001_001_0;
  localparam logic [8:0] O_STRT = 9'b00001_001_1;
  localparam logic [8:0] O_IL   = 9'b00111_010_0;
  localparam logic [8:0] O_BR   = 9'b11111_110_0;

  logic        clk = 1'b0;
  logic        rst, lock, br, done;
  logic [31:0] ir;
  logic        pc_en, if_of_en, of_ex_en, ex_ma_en, ma_rw_en;
  logic        if_of_flush, of_ex_bubble, ex_ma_bubble, mdu_start;
  logic [15:0] stall_cycles, flush_count;

  logic        rst4, lock4, br4;
  logic        pc_en4, if_of_en4, of_ex_en4, ex_ma_en4, ma_rw_en4;
  logic        if_of_flush4, of_ex_bubble4, ex_ma_bubble4, mdu_start4;
  logic [3:0]  stall4, flush4;

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  pipeline_control_unit #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .isDataInterLock(lock), .isBranchTaken(br),
    .input_EX_IR(ir), .mdu_done(done),
    .pc_en(pc_en), .if_of_en(if_of_en), .of_ex_en(of_ex_en),
    .ex_ma_en(ex_ma_en), .ma_rw_en(ma_rw_en),
    .if_of_flush(if_of_flush), .of_ex_bubble(of_ex_bubble),
    .ex_ma_bubble(ex_ma_bubble), .mdu_start(mdu_start),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  pipeline_control_unit #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst4), .isDataInterLock(lock4), .isBranchTaken(br4),
    .input_EX_IR(32'h0), .mdu_done(1'b0),
    .pc_en(pc_en4), .if_of_en(if_of_en4), .of_ex_en(of_ex_en4),
    .ex_ma_en(ex_ma_en4), .ma_rw_en(ma_rw_en4),
    .if_of_flush(if_of_flush4), .of_ex_bubble(of_ex_bubble4),
    .ex_ma_bubble(ex_ma_bubble4), .mdu_start(mdu_start4),
    .stall_cycles(stall4), .flush_count(flush4)
  );

  typedef struct {
    logic        rst;
    logic        lock;
    logic        br;
    logic [4:0]  op;
    logic        done;
    logic [8:0]  exp_out;
    int unsigned exp_stall;  // counter values seen before this cycle's edge
    int unsigned exp_flush;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic r, input logic l, input logic b,
                     input logic [4:0] op, input logic d, input logic [8:0] o,
                     input int unsigned s, input int unsigned f);
    vec_t v;
    v.rst = r; v.lock = l; v.br = b; v.op = op; v.done = d;
    v.exp_out = o; v.exp_stall = s; v.exp_flush = f;
    tv.push_back(v);
  endtask

  task automatic check(input string name, input int unsigned act,
                       input int unsigned req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic int unsigned perf(input int unsigned v);
    return PERF ? v : 0;
  endfunction

  initial begin
    //   rst lock br  op      done out     stall flush
    add(1, 0, 0, OP_ADD, 0, O_RST,  0,  0);  // 0 reset
    add(1, 1, 1, OP_MUL, 1, O_RST,  0,  0);  // 1 reset masks all inputs
    add(0, 0, 0, OP_ADD, 0, O_NORM, 0,  0);  // 2 normal
    add(0, 1, 0, OP_ADD, 0, O_IL,   0,  0);  // 3 interlock
    add(0, 1, 0, OP_ADD, 0, O_IL,   1,  0);  // 4 interlock
    add(0, 0, 0, OP_ADD, 0, O_NORM, 2,  0);  // 5 stall=2
    add(0, 1, 1, OP_ADD, 0, O_BR,   2,  0);  // 6 branch beats interlock
    add(0, 0, 0, OP_ADD, 0, O_NORM, 2,  1);  // 7 flush=1, stall unchanged
    add(0, 0, 0, OP_MUL, 0, O_MDU,  2,  1);  // 8 RUN mul
    add(0, 0, 0, OP_MUL, 1, O_STRT, 3,  1);  // 9 START, done ignored
    add(0, 0, 0, OP_MUL, 0, O_MDU,  4,  1);  // 10 WAIT 1
    add(0, 0, 0, OP_MUL, 0, O_MDU,  5,  1);  // 11 WAIT 2
    add(0, 1, 1, OP_MUL, 0, O_MDU,  6,  1);  // 12 WAIT 3, br/lock ignored
    add(0, 0, 0, OP_MUL, 1, O_MDU,  7,  1);  // 13 WAIT 4, done
    add(0, 0, 0, OP_MUL, 0, O_NORM, 8,  1);  // 14 RELEASE, stall +6
    add(0, 0, 0, OP_DIV, 0, O_MDU,  8,  1);  // 15 RUN div
    add(0, 0, 0, OP_DIV, 0, O_STRT, 9,  1);  // 16 second start pulse
    add(0, 0, 0, OP_DIV, 1, O_MDU,  10, 1);  // 17 WAIT, done
    add(0, 0, 0, OP_MOD, 0, O_NORM, 11, 1);  // 18 RELEASE ignores mdu_op
    add(0, 0, 0, OP_MOD, 0, O_MDU,  11, 1);  // 19 RUN mod
    add(0, 0, 0, OP_MOD, 0, O_STRT, 12, 1);  // 20 START
    add(0, 0, 0, OP_MOD, 0, O_MDU,  13, 1);  // 21 WAIT
    add(1, 0, 0, OP_MOD, 0, O_RST,  14, 1);  // 22 reset in WAIT
    add(0, 0, 0, OP_ADD, 0, O_NORM, 0,  0);  // 23 RUN, counters cleared
    add(0, 0, 0, OP_ADD, 1, O_NORM, 0,  0);  // 24 stray done in RUN

    rst4 = 1'b1; lock4 = 1'b0; br4 = 1'b0;

    foreach (tv[i]) begin
      rst  = tv[i].rst;
      lock = tv[i].lock;
      br   = tv[i].br;
      done = tv[i].done;
      ir   = {tv[i].op, 27'($urandom)};
      @(negedge clk);
      check($sformatf("outputs[%0d]", i),
            {pc_en, if_of_en, of_ex_en, ex_ma_en, ma_rw_en,
             if_of_flush, of_ex_bubble, ex_ma_bubble, mdu_start},
            tv[i].exp_out);
      check($sformatf("stall_cycles[%0d]", i), stall_cycles,
            perf(tv[i].exp_stall));
      check($sformatf("flush_count[%0d]", i), flush_count,
            perf(tv[i].exp_flush));
      @(posedge clk); #1;
    end

    // CNT_W=4 saturation: 20 interlock cycles then 20 branch cycles.
    rst4 = 1'b1;
    @(posedge clk); #1;
    rst4 = 1'b0; lock4 = 1'b1;
    for (int unsigned c = 0; c < 20; c++) begin
      @(negedge clk);
      check($sformatf("sat_pc_en[%0d]", c), pc_en4, 0);
      @(posedge clk); #1;
    end
    lock4 = 1'b0; br4 = 1'b1;
    @(negedge clk);
    check("sat_stall_hold", stall4, perf(15));
    check("sat_flush_out", if_of_flush4, 1);
    for (int unsigned c = 0; c < 20; c++) begin
      @(posedge clk); #1;
    end
    br4 = 1'b0;
    @(negedge clk);
    check("sat_flush_hold", flush4, perf(15));
    check("sat_stall_after_br", stall4, perf(15));
    check("sat_normal_out", {pc_en4, if_of_flush4, of_ex_bubble4}, 3'b100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
